rr_grant_arbiter8: RTL and testbench
====================================

Name: rr_grant_arbiter8

Overview:
- 8-requester round-robin arbiter.
- Produces the one-hot 8-bit grant vector consumed directly by the downstream 8-to-3 encoder stage, which converts it to a 3-bit owner index.
- Holds each grant until the owner releases it, drops its request, or exceeds a hold limit.
- Guarantees the grant bus is always either one-hot or all-zero.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  8  request vector; bit i = requester i wants ownership.
- release  input  1  current owner gives up the grant.
- grant  output  8  one-hot grant to the owner; all-zero when no owner.
- grant_valid  output  1  high exactly when grant is non-zero.
- expired  output  1  one-cycle pulse on the cycle after a timeout-forced release.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - grant=8'h00, grant_valid=0, expired=0.
  - State IDLE, priority pointer ptr=0, hold counter hold_cnt=0.
- All outputs are registered; none are combinational from inputs.
- State IDLE:
  - grant=0, grant_valid=0.
  - At an edge with req!=0: select the first set bit of req searching from index ptr upward, wrapping 7->0.
  - At that same edge: grant<=one-hot(selected), grant_valid<=1, hold_cnt<=0, state<=BUSY.
  - Latency is 1 edge from req sampled to grant visible.
  - req==0: stay IDLE.
  - release is ignored in IDLE.
- State BUSY (owner o = index of the set grant bit):
  - Release causes, evaluated each edge:
    - (a) release==1
    - (b) req[o]==0
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
  - Any cause true: grant<=0, grant_valid<=0, ptr<=(o+1) mod 8, hold_cnt<=0, state<=IDLE.
  - Otherwise: hold_cnt<=hold_cnt+1; grant unchanged.
  - Requests from non-owners never affect grant while BUSY.
- expired<=1 on the release edge only when (c) is true and (a) and (b) are both false. Otherwise expired<=0, so it is always a single-cycle pulse.
- A grant therefore lasts at most MAX_HOLD cycles.
- At least one grant=0 cycle always separates consecutive grants, including a re-grant to the same requester.
- ptr changes only on release. The most recent owner becomes lowest priority.
- hold_cnt is 8 bits and never wraps, because (c) fires first. With MAX_HOLD=0 it saturates at 255.
- Downstream note: the encoder maps all-zero to index 7, so consumers must qualify the encoded index with grant_valid.
- Reset asserted mid-BUSY: outputs clear asynchronously and ptr returns to 0. No expired pulse is generated.

Test Plan:
- Reset mid-grant: with grant=8'h04 held, drive rst_n low between edges -> grant=8'h00, grant_valid=0 before the next edge. After rst_n rises with req=8'h84 -> grant=8'h04 (ptr=0 search).
- Basic handshake: after reset, req=8'b10000001 -> grant=8'h01 one edge later. Pulse release for one cycle -> grant=8'h00 for exactly one cycle, then grant=8'h80.
- Rotation: req=8'hFF held, release pulsed in each granted cycle -> grant sequence 01,02,04,08,10,20,40,80,01, each separated by one zero cycle.
- Timeout with MAX_HOLD=4: req=8'h04 held, release=0 ->
  - grant=8'h04 for exactly 4 cycles, then 8'h00.
  - expired=1 for exactly that zero cycle.
  - Then grant=8'h04 again, since the search from ptr=3 wraps to 2.
- Owner drop: grant=8'h10, owner deasserts req[4] with req=8'h11 -> grant=0 next edge, expired=0, then grant=8'h01 (ptr=5 search wraps to 0).
- Simultaneous causes with MAX_HOLD=4: release=1 on the cycle where hold_cnt==3 -> grant clears, expired stays 0. Also confirm MAX_HOLD=0 holds a grant for more than 300 cycles with no expired pulse.

Source files
------------

// File: rtl/rr_grant_arbiter8.sv
// rr_grant_arbiter8: 8-requester round-robin arbiter with hold-until-release
// grants and an optional hold-time limit. The grant bus is registered and is
// always one-hot or all-zero. It feeds the 8-to-3 owner encoder directly.
module rr_grant_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  input  logic       i_release,
  output logic [7:0] o_grant,
  output logic       o_grant_valid,
  output logic       o_expired
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // A value of 0 for MAX_HOLD turns the timeout off.
  // HOLD_LAST is then never used for a release.
  localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_holdCnt;
  logic [7:0] r_grant;
  logic       r_grantValid;
  logic       r_expired;

  state_t     w_nextState;
  logic [2:0] w_nextPtr;
  logic [7:0] w_nextHoldCnt;
  logic [7:0] w_nextGrant;
  logic       w_nextGrantValid;
  logic       w_nextExpired;

  logic [2:0] w_selIdx;
  logic       w_selFound;
  logic [2:0] w_ownerIdx;
  logic       w_ownerReq;
  logic       w_timeout;
  logic       w_releaseNow;

  // Rotating priority search: first requester at or above r_ptr, wrapping 7->0.
  always_comb begin
    w_selIdx   = 3'd0;
    w_selFound = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!w_selFound && i_req[r_ptr + 3'(k)]) begin
        w_selFound = 1'b1;
        w_selIdx   = r_ptr + 3'(k);
      end
    end
  end

  // Owner index recovered from the one-hot grant.
  // This is used to advance the pointer on release.
  always_comb begin
    w_ownerIdx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_grant[i]) begin
        w_ownerIdx = 3'(i);
      end
    end
  end

  assign w_ownerReq   = |(i_req & r_grant);
  assign w_timeout    = TIMEOUT_EN && (r_holdCnt == HOLD_LAST);
  assign w_releaseNow = i_release || !w_ownerReq || w_timeout;

  // Next-state and next-output logic.
  // The expired flag is raised only when the timeout alone forced the release.
  always_comb begin
    w_nextState      = r_state;
    w_nextPtr        = r_ptr;
    w_nextHoldCnt    = r_holdCnt;
    w_nextGrant      = r_grant;
    w_nextGrantValid = r_grantValid;
    w_nextExpired    = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextGrant      = 8'h00;
        w_nextGrantValid = 1'b0;
        if (w_selFound) begin
          w_nextGrant      = 8'd1 << w_selIdx;
          w_nextGrantValid = 1'b1;
          w_nextHoldCnt    = 8'd0;
          w_nextState      = BUSY;
        end
      end
      BUSY: begin
        if (w_releaseNow) begin
          w_nextGrant      = 8'h00;
          w_nextGrantValid = 1'b0;
          w_nextPtr        = w_ownerIdx + 3'd1;
          w_nextHoldCnt    = 8'd0;
          w_nextState      = IDLE;
          w_nextExpired    = w_timeout && !i_release && w_ownerReq;
        end else if (r_holdCnt != 8'hFF) begin
          w_nextHoldCnt = r_holdCnt + 8'd1;
        end
      end
      default: begin
        w_nextState      = IDLE;
        w_nextGrant      = 8'h00;
        w_nextGrantValid = 1'b0;
        w_nextHoldCnt    = 8'd0;
      end
    endcase
  end

  // State and registered outputs.
  // Reset clears them asynchronously, with no expired pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= 3'd0;
      r_holdCnt    <= 8'd0;
      r_grant      <= 8'h00;
      r_grantValid <= 1'b0;
      r_expired    <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_ptr        <= w_nextPtr;
      r_holdCnt    <= w_nextHoldCnt;
      r_grant      <= w_nextGrant;
      r_grantValid <= w_nextGrantValid;
      r_expired    <= w_nextExpired;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grantValid;
  assign o_expired     = r_expired;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// tb_rr_grant_arbiter8: scoreboard bench for the round-robin arbiter.
// Expected results come from a behavioural model that tracks owner and cycles held.
module tb_rr_grant_arbiter8;

  localparam int HOLD_A = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic       valid;
    logic       expired;
  } expect_t;

  logic       clk;
  logic       rstN;
  logic [7:0] reqVec;
  logic       relPulse;
  logic [7:0] grant;
  logic       grantValid;
  logic       expired;

  logic [7:0] req0;
  logic       rel0;
  logic [7:0] grant0;
  logic       grantValid0;
  logic       expired0;

  expect_t expQ[$];
  int      compareCount  = 0;
  int      mismatchCount = 0;

  // Model state: owner index (-1 = none), priority pointer, cycles the grant has been visible.
  int mOwner;
  int mPtr;
  int mHeld;

  rr_grant_arbiter8 #(.MAX_HOLD(HOLD_A)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_req         (reqVec),
    .i_release     (relPulse),
    .o_grant       (grant),
    .o_grant_valid (grantValid),
    .o_expired     (expired)
  );

  rr_grant_arbiter8 #(.MAX_HOLD(0)) dutNoLimit (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_req         (req0),
    .i_release     (rel0),
    .o_grant       (grant0),
    .o_grant_valid (grantValid0),
    .o_expired     (expired0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    compareCount++;
    if (act !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got grant=%02h valid=%0b expired=%0b, want grant=%02h valid=%0b expired=%0b",
               name, $time, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mPtr   = 0;
    mHeld  = 0;
  endtask

  // One clock edge of the arbiter's rules: pick the next requester round-robin.
  // Otherwise keep the grant until release, request drop, or HOLD_A visible cycles.
  task automatic modelStep(input logic [7:0] r, input logic rl, output expect_t e);
    int  idx;
    bit  stillWanted;
    bit  hitLimit;
    e = '0;
    if (mOwner < 0) begin
      for (int k = 0; k < 8; k++) begin
        idx = (mPtr + k) % 8;
        if (mOwner < 0 && r[idx]) begin
          mOwner = idx;
          mHeld  = 1;
        end
      end
      if (mOwner >= 0) begin
        e.grant = 8'(1 << mOwner);
        e.valid = 1'b1;
      end
    end else begin
      stillWanted = r[mOwner];
      hitLimit    = (HOLD_A != 0) && (mHeld >= HOLD_A);
      if (rl || !stillWanted || hitLimit) begin
        e.expired = hitLimit && !rl && stillWanted;
        mPtr      = (mOwner + 1) % 8;
        mOwner    = -1;
        mHeld     = 0;
      end else begin
        mHeld++;
        e.grant = 8'(1 << mOwner);
        e.valid = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, then queue the model's post-edge expectation.
  task automatic applyStimulus(input logic [7:0] r, input logic rl);
    expect_t e;
    reqVec   = r;
    relPulse = rl;
    modelStep(r, rl, e);
    @(posedge clk);
    expQ.push_back(e);
    #1;
  endtask

  // Monitor: compare each queued expectation against the DUT on the falling edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("scoreboard", {grant, grantValid, expired}, {e.grant, e.valid, e.expired});
      end
    end
  end

  // Directed sequences, randomized traffic, then the unlimited-hold instance.
  initial begin
    logic [7:0] curReq;
    logic       curRel;
    int         waitCycles;

    rstN     = 1'b0;
    reqVec   = 8'h00;
    relPulse = 1'b0;
    req0     = 8'h00;
    rel0     = 1'b0;
    modelReset();
    #3;
    checkOutput("reset state", {grant, grantValid, expired}, 10'b0);
    @(negedge clk);
    rstN = 1'b1;
    #1;

    $display("[TB] basic handshake");
    applyStimulus(8'h81, 1'b0);
    applyStimulus(8'h81, 1'b1);
    applyStimulus(8'h81, 1'b0);
    applyStimulus(8'h81, 1'b1);

    $display("[TB] rotation");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'hFF, 1'b0);
      applyStimulus(8'hFF, 1'b1);
    end

    $display("[TB] timeout");
    for (int i = 0; i < 10; i++) applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);

    $display("[TB] release coinciding with limit");
    for (int i = 0; i < 4; i++) applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h04, 1'b1);
    applyStimulus(8'h00, 1'b0);

    $display("[TB] owner drop");
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);

    $display("[TB] reset mid-grant");
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h04, 1'b0);
    @(negedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("async reset", {grant, grantValid, expired}, 10'b0);
    modelReset();
    #1;
    reqVec = 8'h84;
    rstN   = 1'b1;
    applyStimulus(8'h84, 1'b0);
    applyStimulus(8'h84, 1'b1);
    applyStimulus(8'h00, 1'b0);

    $display("[TB] random traffic");
    curReq = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) curReq = 8'($urandom);
      curRel = ($urandom_range(7) == 0);
      applyStimulus(curReq, curRel);
    end
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
    end

    $display("[TB] unlimited hold");
    reqVec = 8'h00;
    req0   = 8'h20;
    @(posedge clk);
    #1;
    for (int i = 0; i < 310; i++) begin
      @(negedge clk);
      checkOutput("no-limit hold", {grant0, grantValid0, expired0}, {8'h20, 1'b1, 1'b0});
    end
    req0 = 8'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("no-limit drop", {grant0, grantValid0, expired0}, 10'b0);

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
